// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Purpose : shared types and default constants for the data-memory arbiter.
//           Imported by the arbiter RTL, its interface and its testbench.
// Contents: arb_state_e  - arbiter FSM states
//           DEF_*        - default parameter values
//           ctr_width()  - width needed to hold the starvation limit
package dmem_arb_pkg;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CORE_RD = 2'd1,
    HOST_RD = 2'd2
  } arb_state_e;

  // Bits needed to count from 0 up to and including 'limit'.
  function automatic int ctr_width(input int limit);
    if (limit < 1) begin
      return 1;
    end else begin
      return $clog2(limit + 1);
    end
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// Purpose : bundles the three buses around the data-memory arbiter.
// Signals : core side   - MemWriteM, MemReadM, ALUResultM, WriteDataM,
//                         ReadDataM, StallM
//           host side   - host_valid, host_we, host_addr, host_wdata,
//                         host_ready, host_rvalid, host_rdata
//           memory side - mem_en, mem_we, mem_addr (word index), mem_wdata,
//                         mem_rdata (one-cycle synchronous read data)
// Modports: slave  - arbiter view
//           master - environment view (core, host and memory together)
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  // core
  logic              MemWriteM;
  logic              MemReadM;
  logic [ADDR_W-1:0] ALUResultM;
  logic [DATA_W-1:0] WriteDataM;
  logic [DATA_W-1:0] ReadDataM;
  logic              StallM;

  // host
  logic              host_valid;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ready;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  // memory
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  MemWriteM, MemReadM, ALUResultM, WriteDataM,
    output ReadDataM, StallM,
    input  host_valid, host_we, host_addr, host_wdata,
    output host_ready, host_rvalid, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output MemWriteM, MemReadM, ALUResultM, WriteDataM,
    input  ReadDataM, StallM,
    output host_valid, host_we, host_addr, host_wdata,
    input  host_ready, host_rvalid, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr
// Purpose : counts cycles the host has been kept waiting and flags when the
//           wait has reached LIMIT so the arbiter must serve the host next.
// Ports   : clk         - clock
//           reset       - synchronous active-high reset, clears the count
//           wait_cyc    - host is requesting and was not granted this cycle
//           grant       - host was granted this cycle, clears the count
//           force_grant - count has reached LIMIT
module arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic wait_cyc,
  input  logic grant,
  output logic force_grant
);

  localparam int              CNT_W   = ctr_width(LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] count_r;

  // Saturating wait counter; a grant always wins over a wait in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (grant) begin
      count_r <= {CNT_W{1'b0}};
    end else if (wait_cyc && (count_r < LIMIT_C)) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign force_grant = (count_r >= LIMIT_C);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Purpose : shares one single-port, one-cycle-read data memory between the
//           pipeline M stage (core) and an external host port. Arbitration
//           and memory issue happen only in IDLE; reads spend one extra
//           cycle in CORE_RD / HOST_RD to return the memory word.
// Ports   : clk   - clock, all state on the rising edge
//           reset - synchronous active-high reset; drops any read in flight
//           bus   - dmem_arbiter_if.slave (core, host and memory buses)
// Build   : DMEM_ARB_FAIR_EN defined   -> host wait counter (arb_starve_ctr)
//                                         forces a host grant after
//                                         STARVE_LIMIT waiting cycles.
//           DMEM_ARB_FAIR_EN undefined -> strict core priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  arb_state_e        state_r;
  arb_state_e        state_next_s;

  logic              core_req_s;
  logic              host_grant_s;
  logic              force_host_s;
  logic              mem_en_s;
  logic              mem_we_s;
  logic              stall_s;
  logic              host_ready_s;
  logic              host_rvalid_s;
  logic [ADDR_W-3:0] core_word_s;
  logic [ADDR_W-3:0] host_word_s;
  logic [ADDR_W-3:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic [DATA_W-1:0] rd_word_s;
  logic              unused_addr_bits_s;

  assign core_req_s  = bus.MemWriteM | bus.MemReadM;
  assign core_word_s = bus.ALUResultM[ADDR_W-1:2];
  assign host_word_s = bus.host_addr[ADDR_W-1:2];
  // Byte offsets are meaningless to a word-wide memory.
  assign unused_addr_bits_s = ^{bus.ALUResultM[1:0], bus.host_addr[1:0]};

`ifdef DMEM_ARB_FAIR_EN
  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk         (clk),
    .reset       (reset),
    .wait_cyc    (bus.host_valid & ~host_grant_s),
    .grant       (host_grant_s),
    .force_grant (force_host_s)
  );
`else
  localparam int unused_starve_limit = STARVE_LIMIT;
  assign force_host_s = 1'b0;
`endif

  // FSM state register; reset abandons CORE_RD/HOST_RD so no data is returned.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state, grant decision and memory/handshake outputs.
  always_comb begin
    state_next_s  = state_r;
    host_grant_s  = 1'b0;
    mem_en_s      = 1'b0;
    mem_we_s      = 1'b0;
    mem_addr_s    = core_word_s;
    mem_wdata_s   = bus.WriteDataM;
    stall_s       = 1'b0;
    host_ready_s  = 1'b0;
    host_rvalid_s = 1'b0;

    if (reset) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.host_valid && (!core_req_s || force_host_s)) begin
            // Host wins: any core request waits behind it.
            host_grant_s = 1'b1;
            host_ready_s = 1'b1;
            mem_en_s     = 1'b1;
            mem_we_s     = bus.host_we;
            mem_addr_s   = host_word_s;
            mem_wdata_s  = bus.host_wdata;
            stall_s      = core_req_s;
            if (bus.host_we) begin
              state_next_s = IDLE;
            end else begin
              state_next_s = HOST_RD;
            end
          end else if (bus.MemWriteM) begin
            // Stores complete in the issue cycle; also wins over a load.
            mem_en_s     = 1'b1;
            mem_we_s     = 1'b1;
            stall_s      = 1'b0;
            state_next_s = IDLE;
          end else if (bus.MemReadM) begin
            // Loads need the next cycle for the synchronous read data.
            mem_en_s     = 1'b1;
            mem_we_s     = 1'b0;
            stall_s      = 1'b1;
            state_next_s = CORE_RD;
          end else begin
            state_next_s = IDLE;
          end
        end

        CORE_RD: begin
          stall_s      = 1'b0;
          state_next_s = IDLE;
        end

        HOST_RD: begin
          host_rvalid_s = 1'b1;
          // A core request arriving here cannot be served until IDLE.
          stall_s       = core_req_s;
          state_next_s  = IDLE;
        end

        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // Read data goes to both consumers; each qualifies it with its own strobe.
  assign rd_word_s       = bus.mem_rdata;
  assign bus.ReadDataM   = rd_word_s;
  assign bus.host_rdata  = rd_word_s;

  assign bus.StallM      = stall_s;
  assign bus.host_ready  = host_ready_s;
  assign bus.host_rvalid = host_rvalid_s;
  assign bus.mem_en      = mem_en_s;
  assign bus.mem_we      = mem_we_s;
  assign bus.mem_addr    = mem_addr_s;
  assign bus.mem_wdata   = mem_wdata_s;

endmodule
